// File: rtl/way3_err_monitor.sv
// way3_err_monitor: edge-detects voter error flags into saturating counters, sticky flags, irq and a scrub sequencer.
// Optional scrub-ack watchdog enabled by defining WAY3_ERR_MON_TIMEOUT_EN.
module way3_err_monitor #(
  parameter int unsigned N      = 4,
  parameter int unsigned CW     = 16,
  parameter int unsigned THRESH = 8,
  parameter int unsigned TO_CYC = 64,
  localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  err1_i,
  input  logic [N-1:0]  err2_i,
  input  logic          clear_i,
  output logic [CW-1:0] err1_cnt_o,
  output logic [CW-1:0] err2_cnt_o,
  output logic [N-1:0]  err1_sticky_o,
  output logic [N-1:0]  err2_sticky_o,
  output logic          irq_o,
  output logic          scrub_req_o,
  output logic [IW-1:0] scrub_id_o,
  input  logic          scrub_ack_i,
  output logic          timeout_o
);
  localparam int unsigned SW = CW + 6;
  typedef enum logic {IDLE, REQ} st_t;
  st_t           state_q, state_d;
  logic [N-1:0]  s1e1_q, s2e1_q, s1e2_q, s2e2_q;
  logic [N-1:0]  stk1_q, stk1_d, stk2_q, stk2_d, pend_q, pend_d;
  logic [CW-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [IW-1:0] id_q, id_d;
  logic          irq_q, irq_d, rearm_q, rearm_d;
  logic [N-1:0]  ev1, ev2, id_mask, clr_mask;
  logic          ack_ok, to_hit;
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] b, input logic [N-1:0] ev);
    logic [SW-1:0] s;
    s = SW'(b);
    for (int i = 0; i < N; i++) s = s + SW'(ev[i]);
    return (s > SW'({CW{1'b1}})) ? {CW{1'b1}} : s[CW-1:0];
  endfunction
  function automatic logic [IW-1:0] lowest(input logic [N-1:0] p);
    logic [IW-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) if (p[i]) r = IW'(i);
    return r;
  endfunction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1e1_q  <= '0;
      s2e1_q  <= '0;
      s1e2_q  <= '0;
      s2e2_q  <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      stk1_q  <= '0;
      stk2_q  <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      id_q    <= '0;
      rearm_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      s1e1_q  <= err1_i;
      s2e1_q  <= s1e1_q;
      s1e2_q  <= err2_i;
      s2e2_q  <= s1e2_q;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      stk1_q  <= stk1_d;
      stk2_q  <= stk2_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      rearm_q <= rearm_d;
      state_q <= state_d;
    end
  end
  always_comb begin
    ev1      = s1e1_q & ~s2e1_q;
    ev2      = s1e2_q & ~s2e2_q;
    id_mask  = N'(1) << id_q;
    ack_ok   = (state_q == REQ) && scrub_ack_i;
    // an err1 event on the voter being scrubbed re-arms it so the ack does not retire it
    clr_mask = ((ack_ok && !rearm_q) || to_hit) ? id_mask : '0;
    pend_d   = ((pend_q & ~clr_mask) | ev1) & ~ev2;
    rearm_d  = (state_q == REQ) && !ack_ok && !to_hit && !(|(ev2 & id_mask)) && (rearm_q || |(ev1 & id_mask));
    cnt1_d   = sat_add(clear_i ? '0 : cnt1_q, ev1);
    cnt2_d   = sat_add(clear_i ? '0 : cnt2_q, ev2);
    stk1_d   = (clear_i ? '0 : stk1_q) | ev1;
    stk2_d   = (clear_i ? '0 : stk2_q) | ev2;
    irq_d    = !clear_i && ((32'(cnt1_q) >= THRESH) || (|stk2_q) || timeout_o);
    state_d  = (state_q == IDLE) ? ((|pend_q) ? REQ : IDLE) : ((ack_ok || to_hit) ? IDLE : REQ);
    id_d     = (state_q == IDLE && |pend_q) ? lowest(pend_q) : id_q;
  end
`ifdef WAY3_ERR_MON_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] wd_q;
  logic          to_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= (state_q == REQ) ? wd_q + 1'b1 : '0;
      to_q <= to_hit || (to_q && !clear_i);
    end
  end
  assign to_hit    = (state_q == REQ) && !scrub_ack_i && (wd_q == TW'(TO_CYC - 1));
  assign timeout_o = to_q;
`else
  assign to_hit    = 1'b0 && (TO_CYC > 0);
  assign timeout_o = 1'b0;
`endif
  assign err1_cnt_o    = cnt1_q;
  assign err2_cnt_o    = cnt2_q;
  assign err1_sticky_o = stk1_q;
  assign err2_sticky_o = stk2_q;
  assign irq_o         = irq_q;
  assign scrub_req_o   = (state_q == REQ);
  assign scrub_id_o    = id_q;
endmodule

// File: tb/tb_way3_err_monitor.sv
// tb_way3_err_monitor: directed bench with a scrub-id scoreboard and a CW=4 instance for saturation.
module tb_way3_err_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  err1 = '0, err2 = '0, err1_s = '0, zero4 = '0;
  logic        clear = 1'b0, ack = 1'b0, ack_s = 1'b1, zero1 = 1'b0;
  logic [15:0] cnt1, cnt2;
  logic [3:0]  stk1, stk2, s_cnt1, s_cnt2, s_stk1, s_stk2;
  logic [1:0]  sid, s_sid;
  logic        irq, req, tmo, s_irq, s_req, s_tmo;
  int          total = 0, bad = 0;
  int          exp_q[$];

  always #5 clk = ~clk;

  way3_err_monitor #(.N(4), .CW(16), .THRESH(8), .TO_CYC(64)) dut (
    .clk_i(clk), .rst_i(rst), .err1_i(err1), .err2_i(err2), .clear_i(clear),
    .err1_cnt_o(cnt1), .err2_cnt_o(cnt2), .err1_sticky_o(stk1), .err2_sticky_o(stk2),
    .irq_o(irq), .scrub_req_o(req), .scrub_id_o(sid), .scrub_ack_i(ack), .timeout_o(tmo));

  way3_err_monitor #(.N(4), .CW(4), .THRESH(8), .TO_CYC(64)) u_sat (
    .clk_i(clk), .rst_i(rst), .err1_i(err1_s), .err2_i(zero4), .clear_i(zero1),
    .err1_cnt_o(s_cnt1), .err2_cnt_o(s_cnt2), .err1_sticky_o(s_stk1), .err2_sticky_o(s_stk2),
    .irq_o(s_irq), .scrub_req_o(s_req), .scrub_id_o(s_sid), .scrub_ack_i(ack_s), .timeout_o(s_tmo));

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse1(input logic [3:0] v);
    err1 = v; step(1); err1 = '0; step(1);
  endtask

  task automatic pulse2(input logic [3:0] v);
    err2 = v; step(1); err2 = '0; step(1);
  endtask

  task automatic wait_req();
    int n = 0;
    int e;
    while (!req && n < 100) begin step(1); n++; end
    chk("req_seen", {31'b0, req}, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk("sb_id", {30'b0, sid}, e);
  endtask

  task automatic do_ack();
    ack = 1'b1; step(1); ack = 1'b0;
    chk("req_drop", {31'b0, req}, 0);
  endtask

  initial begin
    step(3);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_cnt2", cnt2, 0);
    chk("rst_stk1", stk1, 0);
    chk("rst_stk2", stk2, 0);
    chk("rst_irq", irq, 0);
    chk("rst_req", req, 0);
    chk("rst_id", sid, 0);
    chk("rst_tmo", tmo, 0);
    rst = 1'b0;
    step(1);
    // 1: long level is one event
    err1 = 4'b0100; exp_q.push_back(2);
    step(10); err1 = '0;
    wait_req();
    chk("t1_cnt1", cnt1, 1);
    chk("t1_stk1", stk1, 4'b0100);
    do_ack();
    step(3);
    chk("t1_idle", req, 0);
    chk("t1_irq", irq, 0);
    // 2: three simultaneous events, scrubs in index order with an IDLE gap
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    pulse1(4'b1011);
    chk("t2_cnt1", cnt1, 4);
    for (int i = 0; i < 3; i++) begin
      wait_req();
      do_ack();
    end
    step(1);
    chk("t2_gap_req", req, 1'b0 | (exp_q.size() > 0));
    // 3: saturation on the CW=4 instance
    for (int i = 1; i <= 20; i++) begin
      err1_s = 4'b0001; step(1); err1_s = '0; step(1);
      if (i == 7) begin chk("t3_cnt7", s_cnt1, 7); chk("t3_irq7", s_irq, 0); end
      if (i == 9) chk("t3_irq9", s_irq, 1);
    end
    chk("t3_sat", s_cnt1, 15);
    chk("t3_irq", s_irq, 1);
    // 4: rescrub on re-arm, err2 cancels a pending voter
    exp_q.push_back(0);
    pulse1(4'b0001);
    wait_req();
    pulse1(4'b0010);
    exp_q.push_back(0);
    pulse1(4'b0001);
    pulse2(4'b0010);
    step(2);
    chk("t4_hold", req, 1);
    do_ack();
    wait_req();
    do_ack();
    step(5);
    chk("t4_no_scrub1", req, 0);
    chk("t4_cnt1", cnt1, 7);
    chk("t4_cnt2", cnt2, 1);
    chk("t4_stk1", stk1, 4'b1111);
    chk("t4_stk2", stk2, 4'b0010);
    chk("t4_irq", irq, 1);
    // 5: clear coinciding with an event keeps that event
    err1 = 4'b1000; step(1);
    clear = 1'b1; step(1);
    clear = 1'b0; err1 = '0;
    chk("t5_cnt1", cnt1, 1);
    chk("t5_stk1", stk1, 4'b1000);
    chk("t5_cnt2", cnt2, 0);
    chk("t5_stk2", stk2, 0);
    chk("t5_irq0", irq, 0);
    exp_q.push_back(3);
    wait_req();
    chk("t5_irq1", irq, 0);
    do_ack();
    // orphan ack while idle
    ack = 1'b1; step(1); ack = 1'b0; step(2);
    chk("orphan_ack", req, 0);
    // 6: never ack
    exp_q.push_back(2);
    pulse1(4'b0100);
    wait_req();
    chk("t6_irq_pre", irq, 0);
`ifdef WAY3_ERR_MON_TIMEOUT_EN
    step(63);
    chk("t6_req63", req, 1);
    step(1);
    chk("t6_req_drop", req, 0);
    chk("t6_tmo", tmo, 1);
    step(1);
    chk("t6_irq", irq, 1);
    step(3);
    chk("t6_no_retry", req, 0);
    clear = 1'b1; step(1); clear = 1'b0;
    chk("t6_tmo_clr", tmo, 0);
`else
    step(1000);
    chk("t6_req_held", req, 1);
    chk("t6_tmo", tmo, 0);
    do_ack();
`endif
    // reset mid-scrub
    exp_q.push_back(1);
    pulse1(4'b0010);
    wait_req();
    rst = 1'b1; step(1);
    chk("rst_mid_req", req, 0);
    chk("rst_mid_cnt", cnt1, 0);
    rst = 1'b0;
    ack = 1'b1; step(1); ack = 1'b0; step(3);
    chk("rst_mid_idle", req, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
